tone_sequencer: RTL and testbench

Plays a programmable sequence of tones by driving the divisor and reset inputs of clock_divider_top. A small note table holds {divisor, duration} pairs. The sequencer steps through the table, holding each divisor for its duration in clock cycles and silencing the divider for a gap between notes. It sits between board-level control (keys/switches) and the divider that feeds the audio output.

---
 rtl/tone_sequencer.sv | 152 +++++++++++++++
 tb/tb_tone_sequencer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/tone_sequencer.sv
// Note-table sequencer that drives the divisor and silencing reset of clock_divider_top.
// Each entry is held for its duration, followed by a fixed silent gap.
module tone_sequencer #(
   parameter int DIV_W      = 32,
   parameter int DUR_W      = 32,
   parameter int NUM_NOTES  = 8,
   parameter int GAP_CYCLES = 1000,
   localparam int IDX_W     = $clog2(NUM_NOTES)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic             stop,
   input  logic             loop,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_addr,
   input  logic [DIV_W-1:0] wr_divisor,
   input  logic [DUR_W-1:0] wr_duration,
   output logic [DIV_W-1:0] divisor,
   output logic             div_rst,
   output logic             busy,
   output logic [IDX_W-1:0] note_idx,
   output logic             done
);

   localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [GAP_W-1:0] GAP_INIT = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NOTES - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_PLAY, S_GAP, S_ADVANCE, S_DONE
   } state_t;

   state_t             state_q, state_d;
   logic [DIV_W-1:0]   divisor_q, divisor_d;
   logic               div_rst_q, div_rst_d;
   logic               busy_q, busy_d;
   logic [IDX_W-1:0]   note_idx_q, note_idx_d;
   logic               done_q, done_d;
   logic [DUR_W-1:0]   dur_cnt_q, dur_cnt_d;
   logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
   logic               tbl_we;

   // Table has no reset so contents survive a reset pulse
   logic [DIV_W-1:0]   tbl_div_q [NUM_NOTES];
   logic [DUR_W-1:0]   tbl_dur_q [NUM_NOTES];
   logic [DIV_W-1:0]   ld_div;
   logic [DUR_W-1:0]   ld_dur;

   assign ld_div = tbl_div_q[note_idx_q];
   assign ld_dur = tbl_dur_q[note_idx_q];

   always_ff @(posedge clock) begin
      if (tbl_we) begin
         tbl_div_q[wr_addr] <= wr_divisor;
         tbl_dur_q[wr_addr] <= wr_duration;
      end
   end

   always_comb begin
      state_d    = state_q;
      divisor_d  = divisor_q;
      note_idx_d = note_idx_q;
      dur_cnt_d  = dur_cnt_q;
      gap_cnt_d  = gap_cnt_q;
      tbl_we     = 1'b0;
      if (state_q != S_IDLE && stop) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               tbl_we = wr_en;
               if (start && !stop) begin
                  state_d    = S_LOAD;
                  note_idx_d = '0;
               end
            end
            S_LOAD: begin
               if (ld_dur == '0) begin
                  state_d = S_DONE;
               end else begin
                  divisor_d = ld_div;
                  dur_cnt_d = ld_dur - DUR_W'(1);
                  state_d   = S_PLAY;
               end
            end
            S_PLAY: begin
               if (dur_cnt_q == '0) begin
                  if (GAP_CYCLES > 0) begin
                     state_d   = S_GAP;
                     gap_cnt_d = GAP_INIT;
                  end else begin
                     state_d = S_ADVANCE;
                  end
               end else begin
                  dur_cnt_d = dur_cnt_q - DUR_W'(1);
               end
            end
            S_GAP: begin
               if (gap_cnt_q == '0) state_d = S_ADVANCE;
               else gap_cnt_d = gap_cnt_q - GAP_W'(1);
            end
            S_ADVANCE: begin
               if (note_idx_q != LAST_IDX) begin
                  note_idx_d = note_idx_q + IDX_W'(1);
                  state_d    = S_LOAD;
               end else if (loop) begin
                  note_idx_d = '0;
                  state_d    = S_LOAD;
               end else begin
                  state_d = S_DONE;
               end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
      // Outputs are registered, so decode them from the state being entered
      div_rst_d = !((state_d == S_PLAY) && (divisor_d != '0));
      busy_d    = (state_d != S_IDLE);
      done_d    = (state_d == S_DONE);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         divisor_q  <= '0;
         div_rst_q  <= 1'b1;
         busy_q     <= 1'b0;
         note_idx_q <= '0;
         done_q     <= 1'b0;
         dur_cnt_q  <= '0;
         gap_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         divisor_q  <= divisor_d;
         div_rst_q  <= div_rst_d;
         busy_q     <= busy_d;
         note_idx_q <= note_idx_d;
         done_q     <= done_d;
         dur_cnt_q  <= dur_cnt_d;
         gap_cnt_q  <= gap_cnt_d;
      end
   end

   assign divisor  = divisor_q;
   assign div_rst  = div_rst_q;
   assign busy     = busy_q;
   assign note_idx = note_idx_q;
   assign done     = done_q;

endmodule

// File: tb/tb_tone_sequencer.sv
// Vector-table bench for tone_sequencer with a small gap so whole sequences stay short.
module tb_tone_sequencer;

   localparam int DIV_W = 32;
   localparam int DUR_W = 32;
   localparam int NUM_NOTES = 8;
   localparam int GAP_CYCLES = 2;

   logic              clock = 1'b0;
   logic              reset = 1'b0;
   logic              start = 1'b0, stop = 1'b0, loop = 1'b0, wr_en = 1'b0;
   logic [2:0]        wr_addr = '0;
   logic [DIV_W-1:0]  wr_divisor = '0;
   logic [DUR_W-1:0]  wr_duration = '0;
   logic [DIV_W-1:0]  divisor;
   logic              div_rst, busy, done;
   logic [2:0]        note_idx;

   tone_sequencer #(.DIV_W(DIV_W), .DUR_W(DUR_W), .NUM_NOTES(NUM_NOTES), .GAP_CYCLES(GAP_CYCLES)) dut (
      .clock(clock), .reset(reset), .start(start), .stop(stop), .loop(loop),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_divisor(wr_divisor), .wr_duration(wr_duration),
      .divisor(divisor), .div_rst(div_rst), .busy(busy), .note_idx(note_idx), .done(done)
   );

   always #5 clock = ~clock;

   typedef struct {
      string       nm;
      bit          start, stop, loop, wr_en;
      bit [2:0]    wr_addr;
      bit [31:0]   wr_div, wr_dur;
      bit [31:0]   e_div;
      bit          e_rst, e_busy;
      bit [2:0]    e_idx;
      bit          e_done;
   } vec_t;

   vec_t      vecs[$];
   vec_t      exp_q[$];
   int        n_vec = 0;
   int        n_bad = 0;
   bit [31:0] cur_div = 0;
   bit [2:0]  cur_idx = 0;
   bit        cur_loop = 0;

   task automatic add(string nm, bit st, bit sp, bit we, bit [2:0] wa, bit [31:0] wd, bit [31:0] wdu,
                      bit [31:0] ediv, bit erst, bit ebusy, bit [2:0] eidx, bit edone);
      vec_t v;
      v.nm = nm; v.start = st; v.stop = sp; v.loop = cur_loop; v.wr_en = we;
      v.wr_addr = wa; v.wr_div = wd; v.wr_dur = wdu;
      v.e_div = ediv; v.e_rst = erst; v.e_busy = ebusy; v.e_idx = eidx; v.e_done = edone;
      vecs.push_back(v);
   endtask

   task automatic idle_v(string nm, int n);
      for (int i = 0; i < n; i++) add(nm, 0, 0, 0, 0, 0, 0, cur_div, 1, 0, cur_idx, 0);
   endtask
   task automatic wr_v(bit [2:0] a, bit [31:0] d, bit [31:0] du);
      add("write", 0, 0, 1, a, d, du, cur_div, 1, 0, cur_idx, 0);
   endtask
   task automatic start_v(string nm);
      add(nm, 1, 0, 0, 0, 0, 0, cur_div, 1, 1, 0, 0);
      cur_idx = 0;
   endtask
   task automatic play_v(string nm, bit [31:0] d, int n);
      for (int i = 0; i < n; i++) add(nm, 0, 0, 0, 0, 0, 0, d, (d == 0), 1, cur_idx, 0);
      cur_div = d;
   endtask
   // gap cycles plus the advance cycle: silent, index unchanged
   task automatic gapadv_v(string nm);
      for (int i = 0; i < GAP_CYCLES + 1; i++) add(nm, 0, 0, 0, 0, 0, 0, cur_div, 1, 1, cur_idx, 0);
   endtask
   task automatic note_v(string nm, bit [31:0] d, int n);
      play_v(nm, d, n);
      gapadv_v({nm, "_gap"});
   endtask
   task automatic load_v(string nm, bit [2:0] k);
      add(nm, 0, 0, 0, 0, 0, 0, cur_div, 1, 1, k, 0);
      cur_idx = k;
   endtask
   task automatic done_v(string nm);
      add(nm, 0, 0, 0, 0, 0, 0, cur_div, 1, 1, cur_idx, 1);
   endtask
   task automatic stop_v(string nm);
      add(nm, 0, 1, 0, 0, 0, 0, cur_div, 1, 0, cur_idx, 0);
   endtask

   task automatic check(vec_t e);
      n_vec++;
      if (divisor !== e.e_div || div_rst !== e.e_rst || busy !== e.e_busy ||
          note_idx !== e.e_idx || done !== e.e_done) begin
         n_bad++;
         $display("FAIL %s: got div=%0d rst=%0b busy=%0b idx=%0d done=%0b, want div=%0d rst=%0b busy=%0b idx=%0d done=%0b",
                  e.nm, divisor, div_rst, busy, note_idx, done,
                  e.e_div, e.e_rst, e.e_busy, e.e_idx, e.e_done);
      end
   endtask

   task automatic run_vecs();
      vec_t v, e;
      while (vecs.size() > 0) begin
         v = vecs.pop_front();
         start = v.start; stop = v.stop; loop = v.loop; wr_en = v.wr_en;
         wr_addr = v.wr_addr; wr_divisor = v.wr_div; wr_duration = v.wr_dur;
         exp_q.push_back(v);
         @(posedge clock);
         #1;
         e = exp_q.pop_front();
         check(e);
      end
      start = 0; stop = 0; wr_en = 0;
   endtask

   task automatic reset_check(string nm);
      vec_t e;
      e.nm = nm; e.e_div = 0; e.e_rst = 1; e.e_busy = 0; e.e_idx = 0; e.e_done = 0;
      check(e);
   endtask

   initial begin
      #12;
      reset_check("reset_state");
      #1 reset = 1'b1;
      @(posedge clock);
      #1;

      idle_v("post_reset_idle", 5);

      // single note followed by end marker
      wr_v(0, 113636, 5);
      wr_v(1, 0, 0);
      idle_v("idle", 1);
      start_v("single_load0");
      note_v("single_play", 113636, 5);
      load_v("single_load1", 1);
      done_v("single_done");
      idle_v("single_after", 2);

      // rest entry then a tone
      wr_v(0, 0, 4);
      wr_v(1, 50000, 3);
      wr_v(2, 0, 0);
      start_v("rest_load0");
      note_v("rest_play", 0, 4);
      load_v("rest_load1", 1);
      note_v("tone_play", 50000, 3);
      load_v("rest_load2", 2);
      done_v("rest_done");
      idle_v("rest_after", 1);

      // full table with looping, loop dropped during second pass
      for (int i = 0; i < NUM_NOTES; i++) wr_v(3'(i), 32'(1000 + i), 2);
      cur_loop = 1;
      start_v("loop_start");
      for (int i = 0; i < NUM_NOTES; i++) begin
         note_v("loop_pass1", 32'(1000 + i), 2);
         load_v("loop_load", (i < NUM_NOTES - 1) ? 3'(i + 1) : 3'd0);
      end
      cur_loop = 0;
      for (int i = 0; i < NUM_NOTES; i++) begin
         note_v("loop_pass2", 32'(1000 + i), 2);
         if (i < NUM_NOTES - 1) load_v("loop_load", 3'(i + 1));
      end
      done_v("loop_done");
      idle_v("loop_after", 1);

      // stop in the third play cycle of a 10-cycle note, then restart
      wr_v(0, 777, 10);
      start_v("stop_load");
      play_v("stop_play", 777, 3);
      stop_v("stop_abort");
      idle_v("stop_idle", 3);
      start_v("restart_load");
      play_v("restart_play", 777, 2);
      stop_v("restart_abort");

      // write while busy must be ignored
      start_v("guard_load");
      play_v("guard_play", 777, 1);
      add("guard_wr_busy", 0, 0, 1, 0, 1, 3, 777, 0, 1, 0, 0);
      stop_v("guard_abort");
      idle_v("guard_idle", 1);
      start_v("guard_reload");
      play_v("guard_replay", 777, 2);
      stop_v("guard_abort2");
      add("start_and_stop", 1, 1, 0, 0, 0, 0, cur_div, 1, 0, cur_idx, 0);
      idle_v("start_stop_idle", 2);

      // write and start in the same cycle: LOAD sees the new entry
      add("wr_start", 1, 0, 1, 0, 4242, 1, cur_div, 1, 1, 0, 0);
      cur_idx = 0;
      note_v("wr_start_play", 4242, 1);
      load_v("wr_start_load1", 1);
      play_v("wr_start_play1", 1001, 1);
      stop_v("wr_start_abort");
      idle_v("idle", 1);

      // end marker at entry 0: busy for LOAD and DONE only
      wr_v(0, 5, 0);
      start_v("empty_load");
      done_v("empty_done");
      idle_v("empty_after", 2);

      // into a note, then async reset mid-play
      wr_v(0, 777, 10);
      start_v("arst_load");
      play_v("arst_play", 777, 3);
      run_vecs();

      #2 reset = 1'b0;
      #1 reset_check("async_reset_mid_play");
      #1 reset = 1'b1;
      @(posedge clock);
      #1;
      cur_div = 0;
      cur_idx = 0;
      idle_v("post_arst_idle", 1);
      start_v("retained_load");
      play_v("retained_play", 777, 3);
      stop_v("retained_abort");
      idle_v("idle", 1);
      run_vecs();

      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
